// File: rtl/i_memory.sv
// i_memory: MEM stage of the five-stage MIPS pipeline.
// Resolves the branch, performs word loads/stores against a private data
// memory and drives the MEM/WB latch. Optional feature macro:
// DMEM_MULTICYCLE_EN -- each memory access takes LATENCY cycles and stalls
// the upstream stages while it is in progress.
module i_memory #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [1:0]  wb_ctl,
   input  logic [2:0]  m_ctl,
   input  logic        zero,
   input  logic [31:0] alu_result,
   input  logic [31:0] rdata2,
   input  logic [4:0]  rd,
   output logic        PCSrc,
   output logic        stall,
   output logic [1:0]  MEM_WB_wb,
   output logic [31:0] MEM_WB_read_data,
   output logic [31:0] MEM_WB_alu_result,
   output logic [4:0]  MEM_WB_rd,
   output logic        MEM_WB_valid
);

   localparam int AW = $clog2(DEPTH);

   // Data memory starts cleared and is deliberately left out of reset.
   logic [31:0] mem_q [DEPTH] = '{default: 32'h0000_0000};

   logic [AW-1:0] idx_s;
   logic          mem_op_s;
   logic          is_load_s;
   logic          is_store_s;
   logic          stall_s;
   logic          complete_s;

   logic [1:0]    wb_q,    wb_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   alu_q,   alu_d;
   logic [4:0]    rd_q,    rd_d;
   logic          valid_q, valid_d;

   assign idx_s      = alu_result[AW+1:2];
   assign is_load_s  = in_valid & m_ctl[1];
   assign is_store_s = in_valid & m_ctl[0];
   assign mem_op_s   = is_load_s | is_store_s;
   assign complete_s = ~stall_s;

   assign PCSrc = in_valid & m_ctl[2] & zero;
   assign stall = stall_s;

`ifdef DMEM_MULTICYCLE_EN
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0] state_q, state_d;
   logic [3:0] cnt_q,   cnt_d;

   // Access-latency FSM: stall is raised for all but the final cycle of an access.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op_s && (LATENCY > 1)) begin
               stall_s = 1'b1;
               cnt_d   = 4'(LATENCY - 2);
               state_d = S_WAIT;
            end else begin
               stall_s = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               stall_s = 1'b1;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               stall_s = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // FSM state and countdown registers; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   // Single-cycle build: every access completes immediately.
   always_comb begin
      stall_s = 1'b0;
   end
`endif

   // Next MEM/WB contents: load from inputs on completion, bubble while stalled.
   always_comb begin
      wb_d    = wb_q;
      rdata_d = rdata_q;
      alu_d   = alu_q;
      rd_d    = rd_q;
      valid_d = 1'b0;
      if (complete_s) begin
         wb_d    = wb_ctl;
         rdata_d = is_load_s ? mem_q[idx_s] : 32'h0000_0000;
         alu_d   = alu_result;
         rd_d    = rd;
         valid_d = in_valid;
      end else begin
         valid_d = 1'b0;
      end
   end

   // MEM/WB pipeline latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q    <= 2'b00;
         rdata_q <= 32'h0000_0000;
         alu_q   <= 32'h0000_0000;
         rd_q    <= 5'd0;
         valid_q <= 1'b0;
      end else begin
         wb_q    <= wb_d;
         rdata_q <= rdata_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
      end
   end

   // Store port: the read above sees pre-write data, giving read-before-write.
   always_ff @(posedge clk) begin
      if (!rst && complete_s && is_store_s) begin
         mem_q[idx_s] <= rdata2;
      end
   end

   assign MEM_WB_wb         = wb_q;
   assign MEM_WB_read_data  = rdata_q;
   assign MEM_WB_alu_result = alu_q;
   assign MEM_WB_rd         = rd_q;
   assign MEM_WB_valid      = valid_q;

endmodule

// File: tb/tb_i_memory.sv
// Self-checking bench for i_memory: directed vectors, expected MEM/WB
// contents queued at issue time and popped by an independent monitor.
module tb_i_memory;

`ifdef DMEM_MULTICYCLE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  wb_ctl;
   logic [2:0]  m_ctl;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2;
   logic [4:0]  rd;
   logic        PCSrc;
   logic        stall;
   logic [1:0]  MEM_WB_wb;
   logic [31:0] MEM_WB_read_data;
   logic [31:0] MEM_WB_alu_result;
   logic [4:0]  MEM_WB_rd;
   logic        MEM_WB_valid;

   int n_cmp = 0;
   int n_err = 0;
   logic [70:0] exp_q [$];
   logic        mon_en = 1'b0;

   i_memory #(.DEPTH(256), .LATENCY(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
      .zero(zero), .alu_result(alu_result), .rdata2(rdata2), .rd(rd),
      .PCSrc(PCSrc), .stall(stall), .MEM_WB_wb(MEM_WB_wb),
      .MEM_WB_read_data(MEM_WB_read_data), .MEM_WB_alu_result(MEM_WB_alu_result),
      .MEM_WB_rd(MEM_WB_rd), .MEM_WB_valid(MEM_WB_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [70:0] act, input logic [70:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every valid MEM/WB presentation is matched against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && MEM_WB_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 71'd1, 71'd0);
            end else begin
               check("memwb", {MEM_WB_wb, MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_rd},
                     exp_q.pop_front());
            end
         end
      end
   end

   // Drive one instruction, hold it for its full latency, check stall/PCSrc/bubbles.
   task automatic issue(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic z, input logic [31:0] alu, input logic [31:0] d2,
                        input logic [4:0] r, input logic [31:0] exp_rdata,
                        input logic exp_pc);
      logic memop;
      int   ncyc;
      in_valid = v; wb_ctl = wb; m_ctl = m; zero = z;
      alu_result = alu; rdata2 = d2; rd = r;
      memop = v & (m[1] | m[0]);
      ncyc  = memop ? LAT : 1;
      if (v) exp_q.push_back({wb, exp_rdata, alu, r});
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c == 1) check("pcsrc", {70'd0, PCSrc}, {70'd0, exp_pc});
         check("stall", {70'd0, stall}, {70'd0, (c < ncyc)});
         if (c > 1) check("bubble_valid", {70'd0, MEM_WB_valid}, 71'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; m_ctl = 3'b000; wb_ctl = 2'b00; zero = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; wb_ctl = 2'b00; m_ctl = 3'b000; zero = 1'b0;
      alu_result = 32'h0; rdata2 = 32'h0; rd = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {MEM_WB_wb, MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_rd},
            71'd0);
      check("reset_valid_stall", {69'd0, MEM_WB_valid, stall}, 71'd0);
      check("reset_pcsrc", {70'd0, PCSrc}, 71'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // store then load, back to back
      issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h10,  32'hDEADBEEF, 5'd0, 32'h0,        1'b0);
      issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h10,  32'h0,        5'd5, 32'hDEADBEEF, 1'b0);
      // branch resolution
      issue(1'b1, 2'b00, 3'b100, 1'b1, 32'h0,   32'h0,        5'd0, 32'h0,        1'b1);
      issue(1'b1, 2'b00, 3'b100, 1'b0, 32'h4,   32'h0,        5'd0, 32'h0,        1'b0);
      issue(1'b0, 2'b00, 3'b100, 1'b1, 32'h8,   32'h0,        5'd0, 32'h0,        1'b0);
      // R-type: read data forced to zero
      issue(1'b1, 2'b10, 3'b000, 1'b0, 32'h55,  32'h77,       5'd7, 32'h0,        1'b0);
      // address wrap modulo DEPTH words
      issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h400, 32'h12345678, 5'd0, 32'h0,        1'b0);
      issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h000, 32'h0,        5'd9, 32'h12345678, 1'b0);
      issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h003, 32'h0,        5'd10, 32'h12345678, 1'b0);
      // read-before-write
      issue(1'b1, 2'b00, 3'b001, 1'b0, 32'h20,  32'hA,        5'd0, 32'h0,        1'b0);
      issue(1'b1, 2'b11, 3'b011, 1'b0, 32'h20,  32'hB,        5'd3, 32'hA,        1'b0);
      issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h20,  32'h0,        5'd4, 32'hB,        1'b0);
      idle(2);

      // reset in the middle of a store: no write, outputs cleared
      in_valid = 1'b1; wb_ctl = 2'b00; m_ctl = 3'b001; zero = 1'b0;
      alu_result = 32'h40; rdata2 = 32'hFFFFFFFF; rd = 5'd0;
      if (LAT >= 3) begin
         @(negedge clk);
         check("rst_pre_stall", {70'd0, stall}, 71'd1);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; m_ctl = 3'b000;
      @(negedge clk);
      check("rst_mid_outputs", {MEM_WB_wb, MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_rd},
            71'd0);
      check("rst_mid_valid_stall", {69'd0, MEM_WB_valid, stall}, 71'd0);
      @(posedge clk); #1;
      issue(1'b1, 2'b11, 3'b010, 1'b0, 32'h40,  32'h0,        5'd6, 32'h0,        1'b0);
      idle(3);
      check("queue_drained", 71'(exp_q.size()), 71'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i_memory.md
# i_memory

MEM stage of the five-stage MIPS pipeline, directly downstream of `i_execute`. It consumes the EX/MEM latch outputs: control, ALU result, store data, destination register and `zero`. It resolves the branch decision, performs word loads and stores against a private data memory, and drives the MEM/WB latch consumed by write-back. Under the multicycle option it stalls upstream stages for the duration of each memory access.

## Interface
Parameters:
- `DEPTH`, 256, data memory size in 32-bit words; power of two.
- `LATENCY`, 3, cycles per memory access when `DMEM_MULTICYCLE_EN` is defined; legal range 1..15.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: EX/MEM holds a real instruction.
- `wb_ctl` in 2: [1] regwrite, [0] memtoreg; passed through to WB.
- `m_ctl` in 3: [2] branch, [1] memread, [0] memwrite.
- `zero` in 1: ALU zero flag.
- `alu_result` in 32: effective address or ALU value.
- `rdata2` in 32: store data.
- `rd` in 5: destination register.
- `PCSrc` out 1: branch taken, to fetch.
- `stall` out 1: hold EX/MEM and upstream stages.
- `MEM_WB_wb` out 2: registered `wb_ctl`.
- `MEM_WB_read_data` out 32: registered load data.
- `MEM_WB_alu_result` out 32: registered `alu_result`.
- `MEM_WB_rd` out 5: registered `rd`.
- `MEM_WB_valid` out 1: MEM/WB holds a real instruction.

## Operation
- Memory op: `in_valid & (memread | memwrite)`.
- Word index: `alu_result[log2(DEPTH)+1:2]`. Bits [1:0] and higher address bits are ignored, so addresses wrap modulo `DEPTH`.
- Branch resolution: `PCSrc = in_valid & branch & zero`. It is combinational and is asserted regardless of `stall`.
- Store: at the completing edge, `mem[idx] <= rdata2`.
- Load: at the completing edge, `MEM_WB_read_data <= mem[idx]`.
- `memread` and `memwrite` both set: read-before-write. The pre-write contents go to `MEM_WB_read_data`, then the new value is stored.
- Non-load instructions: `MEM_WB_read_data <= 0`.
- Completing edge:
  - All MEM_WB registers load from the current inputs.
  - `MEM_WB_valid <= in_valid`.
- Stalled edge:
  - `MEM_WB_valid <= 0` (bubble).
  - Other MEM_WB registers hold.
  - Memory is untouched.
- Memory contents are initialised to zero at time 0 and are not affected by `rst`.
- Multicycle FSM, with `DMEM_MULTICYCLE_EN` defined:
  - IDLE:
    - Memory op with `LATENCY>1`: `stall=1`, load `cnt = LATENCY-2`, go to WAIT.
    - Otherwise: complete this cycle.
  - WAIT:
    - `stall = 1` while `cnt != 0`; decrement `cnt`.
    - When `cnt == 0`: `stall = 0`, complete at this edge, return to IDLE.
  - `stall` is combinational from state, `cnt` and the inputs.
- Upstream must hold all inputs stable while `stall=1`. Input changes during WAIT are undefined.

## Timing
- Reset values:
  - `MEM_WB_*` all 0, `MEM_WB_valid=0`.
  - FSM in IDLE, `cnt=0`.
  - `stall=0` the cycle after reset.
  - `PCSrc` follows its inputs.
- Non-memory instruction: 1 cycle; MEM_WB updated at the next edge.
- Memory op (multicycle): occupies exactly `LATENCY` cycles.
  - `stall` is high for the first `LATENCY-1` cycles.
  - MEM_WB is updated at the edge ending cycle `LATENCY`.
- Back-to-back memory ops: the second op is accepted in the cycle after the first completes, with no extra bubble.
- Reset mid-access: the access is aborted, no write is performed, and the FSM returns to IDLE.
- `LATENCY=1` behaves identically to the single-cycle build.

## Configuration
- `DMEM_MULTICYCLE_EN` defined:
  - FSM and counter are present.
  - Memory ops take `LATENCY` cycles and assert `stall`.
- `DMEM_MULTICYCLE_EN` undefined:
  - All instructions complete in 1 cycle.
  - `stall` is tied to 0.
  - The `LATENCY` parameter is ignored.

## Test plan
- Store/load: sw with `alu_result=0x10`, `rdata2=0xDEADBEEF`, then lw with `alu_result=0x10`, `rd=5`, `wb_ctl=2'b11` -> `MEM_WB_read_data=0xDEADBEEF`, `MEM_WB_rd=5`, `MEM_WB_valid=1`.
- Multicycle, `LATENCY=3`: lw held stable -> `stall=1` for 2 cycles and `MEM_WB_valid=0` during them; `MEM_WB_valid=1` and data valid after the 3rd edge; `stall=0` in the 3rd cycle.
- Branch: `m_ctl=3'b100`, `zero=1`, `in_valid=1` -> `PCSrc=1` in the same cycle; `zero=0` -> 0; `in_valid=0` -> 0.
- Wrap, `DEPTH=256`: sw 0x12345678 at `alu_result=0x400`, lw at `0x000` -> 0x12345678; lw at `0x003` -> same word.
- Reset mid-access, `LATENCY=3`: sw 0xFFFFFFFF to an address holding 0, `rst` asserted in the 2nd stall cycle -> all MEM_WB outputs 0, `stall=0` next cycle; a later lw of that address returns 0.
- Read-before-write: `m_ctl=3'b011` at an address holding 0xA, `rdata2=0xB` -> `MEM_WB_read_data=0xA`; a subsequent lw returns 0xB.
